// File: rtl/jt49_mixseq.sv
// jt49_mixseq: time-multiplexed three-channel log-to-linear mixer.
// The channels are snapshotted on cen and pass one at a time through a single
// shared lookup table. Their sum is then scaled and saturated to 8 bits for
// jt49_dcrm2.din.
module jt49_mixseq #(
  parameter int unsigned GAIN_SHIFT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic [4:0] lvl_a,
  input  logic [4:0] lvl_b,
  input  logic [4:0] lvl_c,
  input  logic [2:0] mute,
  output logic [7:0] dout,
  output logic       dout_valid,
  output logic       busy
);

  typedef enum logic [2:0] {StIdle, StAccA, StAccB, StAccC, StOut} state_e;

  state_e     state_q;
  logic [9:0] acc_q;
  logic [4:0] snap_a_q, snap_b_q, snap_c_q;
  logic [2:0] snap_mute_q;

  logic [4:0] sel_lvl;
  logic       sel_mute;
  logic [7:0] lin_val;
  logic [9:0] contrib;
  logic [9:0] scaled;
  logic [7:0] sat;

  // Route the channel that the current state accumulates into the shared table.
  always_comb begin
    sel_lvl  = 5'd0;
    sel_mute = 1'b1;
    case (state_q)
      StAccA: begin sel_lvl = snap_a_q; sel_mute = snap_mute_q[0]; end
      StAccB: begin sel_lvl = snap_b_q; sel_mute = snap_mute_q[1]; end
      StAccC: begin sel_lvl = snap_c_q; sel_mute = snap_mute_q[2]; end
      default: begin sel_lvl = 5'd0; sel_mute = 1'b1; end
    endcase
  end

  // Shared log-to-linear ROM: round(255 * 2^((n-31)/2)), with 0 mapped to silence.
  always_comb begin
    lin_val = 8'd0;
    case (sel_lvl)
      5'd31: lin_val = 8'd255;
      5'd30: lin_val = 8'd180;
      5'd29: lin_val = 8'd128;
      5'd28: lin_val = 8'd90;
      5'd27: lin_val = 8'd64;
      5'd26: lin_val = 8'd45;
      5'd25: lin_val = 8'd32;
      5'd24: lin_val = 8'd23;
      5'd23: lin_val = 8'd16;
      5'd22: lin_val = 8'd11;
      5'd21: lin_val = 8'd8;
      5'd20: lin_val = 8'd6;
      5'd19: lin_val = 8'd4;
      5'd18: lin_val = 8'd3;
      5'd17: lin_val = 8'd2;
      5'd16: lin_val = 8'd1;
      5'd15: lin_val = 8'd1;
      5'd14: lin_val = 8'd1;
      default: lin_val = 8'd0;
    endcase
  end

  // Compute the channel contribution and the scaled, saturated output value.
  always_comb begin
    contrib = sel_mute ? 10'd0 : {2'b00, lin_val};
    scaled  = acc_q >> GAIN_SHIFT;
    sat     = (scaled > 10'd255) ? 8'hff : scaled[7:0];
  end

  // Sequencer: a cen in any state restarts from a fresh snapshot.
  // A cen in OUT still publishes the finished sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      acc_q       <= 10'd0;
      snap_a_q    <= 5'd0;
      snap_b_q    <= 5'd0;
      snap_c_q    <= 5'd0;
      snap_mute_q <= 3'd0;
      dout        <= 8'd0;
      dout_valid  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      if (state_q == StOut) begin
        dout       <= sat;
        dout_valid <= 1'b1;
      end
      if (cen) begin
        snap_a_q    <= lvl_a;
        snap_b_q    <= lvl_b;
        snap_c_q    <= lvl_c;
        snap_mute_q <= mute;
        acc_q       <= 10'd0;
        state_q     <= StAccA;
        busy        <= 1'b1;
      end else begin
        case (state_q)
          StAccA: begin
            acc_q   <= acc_q + contrib;
            state_q <= StAccB;
            busy    <= 1'b1;
          end
          StAccB: begin
            acc_q   <= acc_q + contrib;
            state_q <= StAccC;
            busy    <= 1'b1;
          end
          StAccC: begin
            acc_q   <= acc_q + contrib;
            state_q <= StOut;
            busy    <= 1'b1;
          end
          default: begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jt49_mixseq.sv
// Testbench for jt49_mixseq.
// Two instances share the inputs, one with GAIN_SHIFT=2 and one with GAIN_SHIFT=0.
module tb_jt49_mixseq;

  logic       clk = 1'b0;
  logic       rst, cen;
  logic [4:0] lvl_a, lvl_b, lvl_c;
  logic [2:0] mute;
  logic [7:0] dout2, dout0;
  logic       dv2, dv0, busy2, busy0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jt49_mixseq #(.GAIN_SHIFT(2)) u_dut2 (
    .clk(clk), .rst(rst), .cen(cen), .lvl_a(lvl_a), .lvl_b(lvl_b), .lvl_c(lvl_c),
    .mute(mute), .dout(dout2), .dout_valid(dv2), .busy(busy2)
  );

  jt49_mixseq #(.GAIN_SHIFT(0)) u_dut0 (
    .clk(clk), .rst(rst), .cen(cen), .lvl_a(lvl_a), .lvl_b(lvl_b), .lvl_c(lvl_c),
    .mute(mute), .dout(dout0), .dout_valid(dv0), .busy(busy0)
  );

  typedef struct {
    logic [4:0] a, b, c;
    logic [2:0] m;
    int         e2, e0;
  } vec_t;

  vec_t vecs[11];
  int   lin_tab[32];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Pulse cen with the given snapshot, scramble inputs afterwards, check the result.
  task automatic run_sample(input logic [4:0] a, b, c, input logic [2:0] m,
                            input int e2, e0, input string tag);
    int lat;
    bit seen;
    @(negedge clk);
    lvl_a = a; lvl_b = b; lvl_c = c; mute = m; cen = 1'b1;
    @(negedge clk);
    cen   = 1'b0;
    lvl_a = 5'($urandom); lvl_b = 5'($urandom); lvl_c = 5'($urandom);
    mute  = 3'($urandom);
    chk({tag, " busy"}, int'(busy2), 1);
    lat  = -1;
    seen = 1'b0;
    for (int i = 1; i <= 10 && !seen; i++) begin
      @(negedge clk);
      if (dv2) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    chk({tag, " latency"}, lat, 4);
    chk({tag, " dout g2"}, int'(dout2), e2);
    chk({tag, " dout g0"}, int'(dout0), e0);
    chk({tag, " valid g0"}, int'(dv0), 1);
    @(negedge clk);
    chk({tag, " valid drop"}, int'(dv2), 0);
    chk({tag, " dout hold"}, int'(dout2), e2);
    chk({tag, " busy idle"}, int'(busy2), 0);
  endtask

  initial begin
    int   pulses, first;
    logic [7:0] prev2;

    lin_tab = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1,
                1, 2, 3, 4, 6, 8, 11, 16, 23, 32, 45, 64, 90, 128, 180, 255};
    vecs[0]  = '{5'd31, 5'd31, 5'd31, 3'b000, 191, 255};
    vecs[1]  = '{5'd29, 5'd0,  5'd0,  3'b000, 32,  128};
    vecs[2]  = '{5'd29, 5'd27, 5'd1,  3'b010, 32,  128};
    vecs[3]  = '{5'd30, 5'd28, 5'd27, 3'b000, 83,  255};
    vecs[4]  = '{5'd0,  5'd0,  5'd0,  3'b000, 0,   0};
    vecs[5]  = '{5'd31, 5'd31, 5'd31, 3'b111, 0,   0};
    vecs[6]  = '{5'd24, 5'd20, 5'd16, 3'b000, 7,   30};
    vecs[7]  = '{5'd31, 5'd0,  5'd0,  3'b110, 63,  255};
    vecs[8]  = '{5'd26, 5'd25, 5'd13, 3'b001, 8,   32};
    vecs[9]  = '{5'd14, 5'd15, 5'd17, 3'b000, 1,   4};
    vecs[10] = '{5'd28, 5'd30, 5'd0,  3'b100, 67,  255};

    // Reset with cen held high: reset must win.
    rst = 1'b1; cen = 1'b1; lvl_a = 5'd31; lvl_b = 5'd31; lvl_c = 5'd31; mute = 3'd0;
    repeat (3) @(negedge clk);
    chk("reset dout g2", int'(dout2), 0);
    chk("reset dout g0", int'(dout0), 0);
    chk("reset valid", int'(dv2), 0);
    chk("reset busy g2", int'(busy2), 0);
    chk("reset busy g0", int'(busy0), 0);
    rst = 1'b0; cen = 1'b0;

    for (int v = 0; v < 11; v++)
      run_sample(vecs[v].a, vecs[v].b, vecs[v].c, vecs[v].m, vecs[v].e2, vecs[v].e0,
                 $sformatf("vec%0d", v));

    // Abort: cen at E0 (all 31), again at E2 (A only); one pulse at E6.
    run_sample(5'd0, 5'd0, 5'd0, 3'd0, 0, 0, "pre abort");
    @(negedge clk);
    lvl_a = 5'd31; lvl_b = 5'd31; lvl_c = 5'd31; mute = 3'd0; cen = 1'b1;
    prev2  = dout2;
    pulses = 0;
    first  = -1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (dv2) begin
        pulses++;
        if (first < 0) first = k;
      end
      if (k == 5) chk("abort dout unchanged", int'(dout2), int'(prev2));
      if (k == 1) cen = 1'b0;
      if (k == 2) begin
        lvl_a = 5'd31; lvl_b = 5'd0; lvl_c = 5'd0; cen = 1'b1;
      end
      if (k == 3) cen = 1'b0;
    end
    chk("abort pulses", pulses, 1);
    chk("abort pulse edge", first, 7);
    chk("abort dout g2", int'(dout2), 63);
    chk("abort dout g0", int'(dout0), 255);

    // Sweep A through the table, cen every 4 clk.
    for (int t = 0; t <= 130; t++) begin
      @(negedge clk);
      if (t >= 5 && (t - 5) % 4 == 0 && (t - 5) / 4 < 32) begin
        chk($sformatf("sweep valid %0d", (t - 5) / 4), int'(dv0), 1);
        chk($sformatf("sweep dout %0d", (t - 5) / 4), int'(dout0), lin_tab[(t - 5) / 4]);
      end else if (t >= 1) begin
        chk($sformatf("sweep no valid t%0d", t), int'(dv0), 0);
      end
      if (t >= 1 && t <= 128) chk($sformatf("sweep busy t%0d", t), int'(busy0), 1);
      if (t == 129) chk("sweep busy end", int'(busy0), 0);
      cen   = (t % 4 == 0 && t < 128);
      lvl_a = 5'(t / 4);
      lvl_b = 5'd0; lvl_c = 5'd0; mute = 3'd0;
    end
    cen = 1'b0;

    // Reset sampled at E2 of a sequence.
    @(negedge clk);
    lvl_a = 5'd31; lvl_b = 5'd31; lvl_c = 5'd31; mute = 3'd0; cen = 1'b1;
    @(negedge clk);
    cen = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst dout g2", int'(dout2), 0);
    chk("midrst dout g0", int'(dout0), 0);
    chk("midrst busy", int'(busy2), 0);
    chk("midrst valid", int'(dv2), 0);
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (dv2 || dv0) pulses++;
    end
    chk("midrst no pulse", pulses, 0);
    chk("midrst busy later", int'(busy2), 0);
    run_sample(5'd31, 5'd31, 5'd31, 3'd0, 191, 255, "after rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
